// File: rtl/basic_adder.sv
// ---------------------------------------------------------------------------
// basic_adder
//
// Purpose:
//   A WIDTH-bit ripple-carry adder with carry-in. It reports the unsigned
//   carry-out and the two's-complement overflow. The sum path is purely
//   combinational, so the datapath ALU can use it with no latency. A
//   registered copy of every result is also provided for pipelined consumers.
//
// Parameters:
//   WIDTH       operand and sum width in bits (minimum 2, default 32)
//
// Ports:
//   clk         clock; the registered outputs update on its rising edge
//   rst         asynchronous, active-high reset; clears the registered outputs
//   A, B        WIDTH-bit operands (two's complement or unsigned)
//   Cin         carry into bit 0
//   S           combinational sum A+B+Cin, low WIDTH bits
//   Cout        combinational carry out of the top bit
//   overFlow    combinational signed-overflow flag
//   S_q         S registered (1-cycle latency)
//   Cout_q      Cout registered
//   overFlow_q  overFlow registered
//   ovf_sticky  (only when BASIC_ADDER_STICKY_OVF_EN is defined) stays set
//               after any clocked overflow until rst clears it
//
// Configuration macro:
//   BASIC_ADDER_STICKY_OVF_EN  adds the ovf_sticky output and its flop
// ---------------------------------------------------------------------------
module basic_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             overFlow,
    output logic [WIDTH-1:0] S_q,
    output logic             Cout_q,
    output logic             overFlow_q
`ifdef BASIC_ADDER_STICKY_OVF_EN
    ,
    output logic             ovf_sticky
`endif
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_overflow;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;

    // Chain of 1-bit full-adder cells. Carry i+1 is either generated by the
    // cell itself or propagated from the cell below.
    always_comb begin
        w_carry    = '0;
        w_sum      = '0;
        w_carry[0] = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i]       = A[i] ^ B[i] ^ w_carry[i];
            w_carry[i + 1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
        end
    end

    // Signed overflow: the carry into the sign bit and the carry out of it
    // disagree. This is the same as saying both operands have the same sign
    // and the result has the other sign.
    assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    assign S        = w_sum;
    assign Cout     = w_carry[WIDTH];
    assign overFlow = w_overflow;

    // Registered copy of the combinational results. Reset clears it at once,
    // but reset never touches the combinational outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_sum      <= w_sum;
            r_cout     <= w_carry[WIDTH];
            r_overflow <= w_overflow;
        end
    end

    assign S_q        = r_sum;
    assign Cout_q     = r_cout;
    assign overFlow_q = r_overflow;

`ifdef BASIC_ADDER_STICKY_OVF_EN
    logic r_ovfSticky;

    // Sticky overflow: set by any overflow seen at a clock edge, held
    // otherwise. Only reset clears it, and reset wins over a set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovfSticky <= 1'b0;
        end else if (w_overflow) begin
            r_ovfSticky <= 1'b1;
        end
    end

    assign ovf_sticky = r_ovfSticky;
`endif

endmodule

// File: tb/tb_basic_adder.sv
// ---------------------------------------------------------------------------
// tb_basic_adder
//
// Purpose:
//   Self-checking bench for basic_adder at WIDTH=32. Each time stimulus is
//   driven, the expected results are pushed to a scoreboard queue. They are
//   popped and compared when the DUT output is sampled. Directed test-plan
//   values are also checked against literal constants.
//   Define BASIC_ADDER_STICKY_OVF_EN to also exercise ovf_sticky.
// ---------------------------------------------------------------------------
module tb_basic_adder;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } expect_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic [W-1:0] S;
    logic         Cout;
    logic         overFlow;
    logic [W-1:0] S_q;
    logic         Cout_q;
    logic         overFlow_q;
`ifdef BASIC_ADDER_STICKY_OVF_EN
    logic         ovf_sticky;
`endif

    expect_t combQueue[$];
    expect_t regQueue[$];

    int assertCount = 0;
    int failCount   = 0;

    basic_adder #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .Cin        (Cin),
        .S          (S),
        .Cout       (Cout),
        .overFlow   (overFlow),
        .S_q        (S_q),
        .Cout_q     (Cout_q),
        .overFlow_q (overFlow_q)
`ifdef BASIC_ADDER_STICKY_OVF_EN
        ,
        .ovf_sticky (ovf_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a 33-bit add for the sum and carry, plus a sign rule
    // for the overflow.
    function automatic expect_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c);
        expect_t      e;
        logic [W:0]   full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.s    = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive operands and push the expected result to both queues.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                 input bit toReg);
        expect_t e;
        e   = model(a, b, c);
        A   = a;
        B   = b;
        Cin = c;
        combQueue.push_back(e);
        if (toReg) regQueue.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        expect_t e;
        if (combQueue.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = combQueue.pop_front();
            check({tag, "_S"},    S,                 e.s);
            check({tag, "_Cout"}, {31'd0, Cout},     {31'd0, e.cout});
            check({tag, "_ovf"},  {31'd0, overFlow}, {31'd0, e.ovf});
        end
    endtask

    task automatic checkRegistered(input string tag);
        expect_t e;
        if (regQueue.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = regQueue.pop_front();
            check({tag, "_S_q"},    S_q,                 e.s);
            check({tag, "_Cout_q"}, {31'd0, Cout_q},     {31'd0, e.cout});
            check({tag, "_ovf_q"},  {31'd0, overFlow_q}, {31'd0, e.ovf});
        end
    endtask

    task automatic checkConst(input string tag, input logic [W-1:0] s, input logic cout,
                              input logic ovf);
        check({tag, "_S_lit"},    S,                 s);
        check({tag, "_Cout_lit"}, {31'd0, Cout},     {31'd0, cout});
        check({tag, "_ovf_lit"},  {31'd0, overFlow}, {31'd0, ovf});
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst = 1'b1;
        A   = '0;
        B   = '0;
        Cin = 1'b0;
        #2;
        check("reset_S_q",    S_q,                 32'd0);
        check("reset_Cout_q", {31'd0, Cout_q},     32'd0);
        check("reset_ovf_q",  {31'd0, overFlow_q}, 32'd0);

        // Combinational tests run while reset is held, because reset must
        // not affect this path.
        applyStimulus(32'h7FFFFFFF, 32'h1, 1'b0, 0); #1;
        checkOutput("pos_wrap");  checkConst("pos_wrap",  32'h80000000, 1'b0, 1'b1);
        applyStimulus(32'h7FFFFFFF, 32'h5, 1'b0, 0); #1;
        checkOutput("pos_wrap5"); checkConst("pos_wrap5", 32'h80000004, 1'b0, 1'b1);
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b0, 0); #1;
        checkOutput("neg_wrap");  checkConst("neg_wrap",  32'h7FFFFFFF, 1'b1, 1'b1);
        applyStimulus(32'h80000000, 32'hFFFFFFFB, 1'b0, 0); #1;
        checkOutput("neg_wrap5"); checkConst("neg_wrap5", 32'h7FFFFFFB, 1'b1, 1'b1);
        applyStimulus(32'd10, 32'hFFFFFFFB, 1'b0, 0); #1;
        checkOutput("10_m5");     checkConst("10_m5",     32'd5,        1'b1, 1'b0);
        applyStimulus(32'd5, 32'd5, 1'b0, 0); #1;
        checkOutput("5_5");       checkConst("5_5",       32'd10,       1'b0, 1'b0);
        applyStimulus(32'hFFFFFFFB, 32'hFFFFFFFB, 1'b0, 0); #1;
        checkOutput("m5_m5");     checkConst("m5_m5",     32'hFFFFFFF6, 1'b1, 1'b0);
        applyStimulus(32'd5, 32'hFFFFFFFB, 1'b0, 0); #1;
        checkOutput("5_m5");      checkConst("5_m5",      32'd0,        1'b1, 1'b0);
        applyStimulus(32'd3, 32'd4, 1'b1, 0); #1;
        checkOutput("cin_3_4");   checkConst("cin_3_4",   32'd8,        1'b0, 1'b0);
        applyStimulus(32'h7FFFFFFF, 32'd0, 1'b1, 0); #1;
        checkOutput("cin_max");   checkConst("cin_max",   32'h80000000, 1'b0, 1'b1);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0); #1;
        checkOutput("all_ones");  checkConst("all_ones",  32'hFFFFFFFF, 1'b1, 1'b0);
        check("held_S_q", S_q, 32'd0);

        // Registered path
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'd5, 32'd5, 1'b0, 1); #1;
        checkOutput("reg_in_5_5");
        @(posedge clk); #1;
        checkRegistered("reg_5_5");

        // Assert reset mid-cycle: the registers clear at once, S is untouched
        #2 rst = 1'b1;
        #1;
        check("async_rst_S_q",    S_q,                 32'd0);
        check("async_rst_Cout_q", {31'd0, Cout_q},     32'd0);
        check("async_rst_ovf_q",  {31'd0, overFlow_q}, 32'd0);
        check("async_rst_S",      S,                   32'd10);

        // Release mid-cycle: the registers stay clear until the next edge
        @(negedge clk); #1 rst = 1'b0;
        #1;
        check("released_pre_edge_S_q", S_q, 32'd0);
        regQueue.push_back(model(32'd5, 32'd5, 1'b0));
        @(posedge clk); #1;
        checkRegistered("released_edge");

        // Back-to-back registered transactions with random operands
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (i == 0) ra = 32'h7FFFFFFF;
            if (i == 0) rb = 32'h7FFFFFFF;
            applyStimulus(ra, rb, rc, 1); #1;
            checkOutput("rand_comb");
            @(posedge clk); #1;
            checkRegistered("rand_reg");
        end

`ifdef BASIC_ADDER_STICKY_OVF_EN
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        applyStimulus(32'd1, 32'd2, 1'b0, 0); #1;
        checkOutput("sticky_setup");
        @(posedge clk); #1;
        check("sticky_clear", {31'd0, ovf_sticky}, 32'd0);
        @(negedge clk);
        applyStimulus(32'h7FFFFFFF, 32'd1, 1'b0, 0); #1;
        checkOutput("sticky_pulse");
        @(posedge clk); #1;
        check("sticky_set", {31'd0, ovf_sticky}, 32'd1);
        @(negedge clk);
        applyStimulus(32'd5, 32'd5, 1'b0, 0); #1;
        checkOutput("sticky_quiet");
        @(posedge clk); #1;
        check("sticky_hold", {31'd0, ovf_sticky}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("sticky_async_rst", {31'd0, ovf_sticky}, 32'd0);
        rst = 1'b0;
`endif

        check("comb_queue_drained", 32'(combQueue.size()), 32'd0);
        check("reg_queue_drained",  32'(regQueue.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
